// File: rtl/icache_if.sv
// ----------------------------------------------------------------------------
// icache_if.sv
// Bus interfaces for the instruction cache.
//
// icache_fetch_if : IFU <-> cache fetch handshake
//   req, addr_inst, inst_fetch_ready  driven by the IFU (master)
//   Cache_ready, inst_valid, inst_i   driven by the cache (slave)
//
// icache_mem_if   : cache <-> instruction memory burst read port
//   mem_req, mem_addr                 driven by the cache (master)
//   mem_gnt, mem_rvalid, mem_rdata,
//   mem_rlast                         driven by the memory (slave)
// ----------------------------------------------------------------------------

interface icache_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr_inst;
    logic              Cache_ready;
    logic              inst_valid;
    logic [63:0]       inst_i;
    logic              inst_fetch_ready;

    modport master (
        output req, addr_inst, inst_fetch_ready,
        input  Cache_ready, inst_valid, inst_i
    );

    modport slave (
        input  req, addr_inst, inst_fetch_ready,
        output Cache_ready, inst_valid, inst_i
    );
endinterface

interface icache_mem_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [63:0]       mem_rdata;
    logic              mem_rlast;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_rlast
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata, mem_rlast
    );
endinterface

// File: rtl/icache.sv
// ----------------------------------------------------------------------------
// icache.sv
// Direct-mapped, read-only instruction cache. Returns the aligned 64-bit
// doubleword containing each fetch address; misses refill a whole line with
// an incrementing burst of 64-bit beats.
//
// Ports
//   clk     in   clock, all state on rising edge
//   rst     in   synchronous reset, active low
//   flush   in   invalidate all lines (fence.i)
//   fetch   icache_fetch_if.slave  : req/addr_inst/inst_fetch_ready in,
//                                    Cache_ready/inst_valid/inst_i out
//   mem     icache_mem_if.master   : mem_req/mem_addr out,
//                                    mem_gnt/mem_rvalid/mem_rdata/mem_rlast in
//   perf_hit, perf_miss  out [63:0]  only when ICACHE_PERF_EN is defined
//
// Optional feature macro: ICACHE_PERF_EN (hit/miss counters).
//
// FSM states
//   state    | meaning
//   IDLE     | waiting for a fetch, Cache_ready=1
//   LOOKUP   | tag compare on latched address; hit answers this cycle
//   MISS_REQ | mem_req held until mem_gnt
//   REFILL   | collecting burst beats into the line
//   RESP     | response register presented until inst_fetch_ready
// ----------------------------------------------------------------------------

module icache #(
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 64,
    parameter int ADDR_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    icache_fetch_if.slave        fetch,
    icache_mem_if.master         mem
`ifdef ICACHE_PERF_EN
    ,
    output logic [63:0]          perf_hit,
    output logic [63:0]          perf_miss
`endif
);

    localparam int BEATS  = LINE_BYTES / 8;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        RESP
    } state_t;

    state_t            state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       resp_q;
    logic [BEAT_W-1:0] beat_q;
    logic              drop_fill_q;
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [63:0]       data_q [SETS][BEATS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [BEAT_W-1:0] want_beat;
    logic [BEAT_W-1:0] beat_nxt;
    logic              hit;
    logic [63:0]       hit_data;
    logic              fill_beat;
    logic              fill_last;

    logic              accept;
    logic              ready_c;
    logic              valid_c;
    logic              mem_req_c;
    logic [63:0]       inst_c;
    logic              unused_low;

    assign idx       = addr_q[OFF_W +: IDX_W];
    assign tag       = addr_q[ADDR_W-1 -: TAG_W];
    // Doubleword position inside the line; zero when a line is a single beat.
    assign want_beat = BEAT_W'((addr_q >> 3) & ADDR_W'(BEATS - 1));
    assign beat_nxt  = BEAT_W'((int'(beat_q) + 1) % BEATS);
    assign unused_low = ^addr_q[2:0];

    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign hit_data  = data_q[idx][want_beat];
    assign fill_beat = (state_q == REFILL) && mem.mem_rvalid;
    assign fill_last = fill_beat && mem.mem_rlast;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        ready_c   = 1'b0;
        valid_c   = 1'b0;
        mem_req_c = 1'b0;
        inst_c    = resp_q;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (fetch.req) begin
                    accept  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    valid_c = 1'b1;
                    inst_c  = hit_data;
                    if (fetch.inst_fetch_ready) begin
                        ready_c = 1'b1;
                        if (fetch.req) begin
                            accept  = 1'b1;
                            state_d = LOOKUP;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_c = 1'b1;
                if (mem.mem_gnt) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (fill_last) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                valid_c = 1'b1;
                if (fetch.inst_fetch_ready) begin
                    ready_c = 1'b1;
                    if (fetch.req) begin
                        accept  = 1'b1;
                        state_d = LOOKUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fetch.Cache_ready = ready_c;
    assign fetch.inst_valid  = valid_c;
    assign fetch.inst_i      = inst_c;
    assign mem.mem_req       = mem_req_c;
    assign mem.mem_addr      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            resp_q      <= '0;
            beat_q      <= '0;
            drop_fill_q <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                addr_q <= fetch.addr_inst;
            end

            // A hit stalled by the IFU is parked in the response register so
            // RESP can present it unchanged even if a flush lands meanwhile.
            if ((state_q == LOOKUP) && hit) begin
                resp_q <= hit_data;
            end

            if ((state_q == MISS_REQ) && mem.mem_gnt) begin
                beat_q <= '0;
            end

            if (fill_beat) begin
                beat_q <= beat_nxt;
                if (beat_q == want_beat) begin
                    resp_q <= mem.mem_rdata;
                end
            end

            if (flush) begin
                valid_q <= '0;
            end else if (fill_last && !drop_fill_q) begin
                valid_q[idx] <= 1'b1;
            end

            // A flush during a refill must keep that line invalid once the
            // burst drains; the flag survives until the FSM is back in IDLE.
            if (flush && ((state_q == MISS_REQ) || (state_q == REFILL))) begin
                drop_fill_q <= 1'b1;
            end else if (state_q == IDLE) begin
                drop_fill_q <= 1'b0;
            end
        end
    end

    // Line storage carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (fill_beat) begin
            data_q[idx][beat_q] <= mem.mem_rdata;
        end
        if (fill_last) begin
            tag_q[idx] <= tag;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_hit  <= '0;
            perf_miss <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit) begin
                perf_hit <= perf_hit + 64'd1;
            end else begin
                perf_miss <= perf_miss + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// ----------------------------------------------------------------------------
// tb_icache.sv
// Testbench for icache. Memory is a fixed function of address, so every
// accepted fetch has a known expected doubleword; accepted fetches push that
// value into a scoreboard queue and a negedge monitor pops and compares on
// each consumed response. Directed sequences cover the named scenarios, then
// a randomized IFU/memory/flush phase runs.
// ----------------------------------------------------------------------------

module tb_icache;

    localparam int LINE_BYTES = 16;
    localparam int SETS       = 64;
    localparam int ADDR_W     = 32;
    localparam int BEATS      = LINE_BYTES / 8;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic flush = 1'b0;

    icache_fetch_if #(.ADDR_W(ADDR_W)) fif ();
    icache_mem_if   #(.ADDR_W(ADDR_W)) mif ();

`ifdef ICACHE_PERF_EN
    logic [63:0] perf_hit;
    logic [63:0] perf_miss;
`endif

    icache #(
        .LINE_BYTES(LINE_BYTES),
        .SETS(SETS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .fetch(fif),
        .mem(mif)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit(perf_hit),
        .perf_miss(perf_miss)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] sb [$];
    logic [31:0] last_acc  = 32'h0;
    int          acc_count = 0;
    bit          mem_gap   = 1'b0;

    // Reference memory contents: a fixed function of the doubleword address.
    function automatic logic [63:0] data_at(input logic [31:0] a);
        logic [31:0] dw;
        dw = a & ~32'h7;
        return {dw ^ 32'hC0DE_0000, ~dw ^ 32'h0000_1234};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    bit          hold_v = 1'b0;
    logic [63:0] hold_d = '0;
    int          beats_seen = 0;

    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            hold_v     = 1'b0;
            beats_seen = 0;
            acc_count  = 0;
        end else begin
            if (fif.inst_valid) begin
                if (hold_v) begin
                    check("resp_stable", fif.inst_i, hold_d);
                end
                if (fif.inst_fetch_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_resp: got %h with no fetch outstanding", fif.inst_i);
                    end else begin
                        check("resp_data", fif.inst_i, sb.pop_front());
                    end
                    hold_v = 1'b0;
                end else begin
                    check("ready_under_stall", {63'd0, fif.Cache_ready}, 64'd0);
                    hold_v = 1'b1;
                    hold_d = fif.inst_i;
                end
            end else if (hold_v) begin
                check("valid_held", 64'd0, 64'd1);
                hold_v = 1'b0;
            end

            if (fif.req && fif.Cache_ready) begin
                sb.push_back(data_at(fif.addr_inst));
                last_acc = fif.addr_inst;
                acc_count++;
            end

            if (mif.mem_rvalid) begin
                if (mif.mem_rlast) begin
                    assert (beats_seen == BEATS - 1)
                        else $error("rlast after %0d beats", beats_seen + 1);
                    beats_seen = 0;
                end else begin
                    beats_seen++;
                end
            end
        end
    end

    // ---------------- memory model ----------------
    initial begin : mem_model
        int          mstate;
        int          beat;
        int          gap;
        bit          send;
        logic        r;
        logic [31:0] base;
        mstate = 0;
        beat   = 0;
        gap    = 0;
        base   = '0;
        mif.mem_gnt    = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rlast  = 1'b0;
        mif.mem_rdata  = '0;
        forever begin
            @(posedge clk);
            r = rst;
            #1;
            mif.mem_gnt    = 1'b0;
            mif.mem_rvalid = 1'b0;
            mif.mem_rlast  = 1'b0;
            if (!r) begin
                mstate = 0;
            end else if (mstate == 0) begin
                if (mif.mem_req && ($urandom_range(0, 2) != 0)) begin
                    check("mem_addr", {32'd0, mif.mem_addr},
                          {32'd0, last_acc & ~32'(LINE_BYTES - 1)});
                    base        = mif.mem_addr;
                    mif.mem_gnt = 1'b1;
                    mstate      = 1;
                    beat        = 0;
                    gap         = 0;
                end
            end else begin
                send = mem_gap ? (gap == 2) : ($urandom_range(0, 3) != 0);
                gap  = send ? 0 : gap + 1;
                if (send) begin
                    mif.mem_rvalid = 1'b1;
                    mif.mem_rdata  = data_at(base + 32'(8 * beat));
                    mif.mem_rlast  = (beat == BEATS - 1);
                    beat++;
                    if (beat == BEATS) begin
                        mstate = 0;
                    end
                end
            end
        end
    end

    // ---------------- IFU helpers ----------------
    task automatic issue(input logic [31:0] a);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        fif.req       = 1'b1;
        fif.addr_inst = a;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = fif.Cache_ready;
            @(posedge clk);
            #1;
            n++;
        end
        fif.req = 1'b0;
        if (!ok) begin
            check("accept_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic wait_resp(output int lat, output bit saw_mem);
        bit done;
        done    = 1'b0;
        lat     = 0;
        saw_mem = 1'b0;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
            if (mif.mem_req) saw_mem = 1'b1;
            if (fif.inst_valid && fif.inst_fetch_ready) done = 1'b1;
        end
        if (!done) begin
            check("resp_timeout", 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, output int lat, output bit saw_mem);
        issue(a);
        wait_resp(lat, saw_mem);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int lat;
        bit sm;
        int n;

        fif.req              = 1'b0;
        fif.addr_inst        = '0;
        fif.inst_fetch_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        @(negedge clk);
        check("rst_ready",    {63'd0, fif.Cache_ready}, 64'd1);
        check("rst_valid",    {63'd0, fif.inst_valid},  64'd0);
        check("rst_inst",     fif.inst_i,               64'd0);
        check("rst_mem_req",  {63'd0, mif.mem_req},     64'd0);
        check("rst_mem_addr", {32'd0, mif.mem_addr},    64'd0);
        @(posedge clk);
        #1;

        // cold miss then hits in the same line
        fetch(32'h8000_0000, lat, sm);
        check("cold_miss_mem", {63'd0, sm}, 64'd1);
`ifdef ICACHE_PERF_EN
        check("perf_miss_1", perf_miss, 64'd1);
        check("perf_hit_0",  perf_hit,  64'd0);
`endif
        fetch(32'h8000_0008, lat, sm);
        check("hit_latency", 64'(lat), 64'd1);
        check("hit_no_mem",  {63'd0, sm}, 64'd0);
`ifdef ICACHE_PERF_EN
        check("perf_hit_1", perf_hit, 64'd1);
`endif
        fetch(32'h8000_0006, lat, sm);
        check("hit_lowbits_latency", 64'(lat), 64'd1);

        // conflict in set 0
        fetch(32'h8000_0400, lat, sm);
        check("conflict_a_miss", {63'd0, sm}, 64'd1);
        fetch(32'h8000_0000, lat, sm);
        check("conflict_b_miss", {63'd0, sm}, 64'd1);
        fetch(32'h8000_0008, lat, sm);
        check("refilled_hit", {63'd0, sm}, 64'd0);

        // backpressure on a hit, then back-to-back accept on release
        fif.inst_fetch_ready = 1'b0;
        issue(32'h8000_0000);
        fif.req       = 1'b1;
        fif.addr_inst = 32'h8000_0008;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", {63'd0, fif.inst_valid},  64'd1);
            check("bp_ready", {63'd0, fif.Cache_ready}, 64'd0);
            check("bp_data",  fif.inst_i, data_at(32'h8000_0000));
        end
        @(posedge clk);
        #1 fif.inst_fetch_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {63'd0, fif.Cache_ready}, 64'd1);
        @(posedge clk);
        #1 fif.req = 1'b0;
        wait_resp(lat, sm);
        check("b2b_hit_latency", 64'(lat), 64'd1);

        // flush between refill beats
        mem_gap = 1'b1;
        fork
            fetch(32'h8000_0010, lat, sm);
            begin
                n = 0;
                while (!mif.mem_rvalid && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
        join
        fetch(32'h8000_0010, lat, sm);
        check("flush_mid_refill_remiss", {63'd0, sm}, 64'd1);
        fetch(32'h8000_0018, lat, sm);
        check("refill_after_flush_hit", {63'd0, sm}, 64'd0);

        // flush coincident with final beat
        fork
            fetch(32'h8000_0020, lat, sm);
            begin
                n = 0;
                while (!(mif.mem_rvalid && mif.mem_rlast) && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
        join
        fetch(32'h8000_0020, lat, sm);
        check("flush_last_beat_remiss", {63'd0, sm}, 64'd1);

        // reset during refill
        fetch(32'h8000_0000, lat, sm);
        fetch(32'h8000_0000, lat, sm);
        check("prefill_hit", {63'd0, sm}, 64'd0);
        issue(32'h8000_0030);
        n = 0;
        while (!mif.mem_rvalid && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_mem_req", {63'd0, mif.mem_req},     64'd0);
        check("midrst_valid",   {63'd0, fif.inst_valid},  64'd0);
        check("midrst_ready",   {63'd0, fif.Cache_ready}, 64'd1);
        @(posedge clk);
        #1;
        fetch(32'h8000_0000, lat, sm);
        check("after_rst_miss", {63'd0, sm}, 64'd1);
        mem_gap = 1'b0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            fif.req              = ($urandom_range(0, 2) != 0);
            fif.addr_inst        = 32'h8000_0000
                                 | ($urandom_range(0, 2) << 10)
                                 | ($urandom_range(0, 3) << 4)
                                 | ($urandom_range(0, 3) << 2)
                                 | $urandom_range(0, 3);
            fif.inst_fetch_ready = ($urandom_range(0, 3) != 0);
            flush                = ($urandom_range(0, 59) == 0);
            @(posedge clk);
            #1;
        end
        fif.req              = 1'b0;
        fif.inst_fetch_ready = 1'b1;
        flush                = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
`ifdef ICACHE_PERF_EN
        check("perf_sum", perf_hit + perf_miss, 64'(acc_count));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
